// File: rtl/std_cache_pkg.sv
// std_cache_pkg: shared entry layout and FSM state type for the dcache ECC scrubber
package std_cache_pkg;
  localparam int SCRUB_WAYS = 8;
  localparam int SCRUB_AW   = 64;
  typedef struct packed {
    logic [SCRUB_WAYS-1:0] way;
    logic [SCRUB_AW-1:0]   addr;
  } scrub_entry_t;
  typedef enum logic [1:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ} scrub_state_e;
endpackage

// File: rtl/dcache_scrub_fifo.sv
// dcache_scrub_fifo: pending-scrub queue; ports clk_i/rst_ni, i_push/i_pop/i_data in, o_data (head)/o_full/o_empty out
module dcache_scrub_fifo #(
  parameter int W     = 72,
  parameter int DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_data,
  output logic         o_full,
  output logic         o_empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wptr, r_rptr;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + (AW+1)'(1);
      if (i_pop) r_rptr <= r_rptr + (AW+1)'(1);
    end
  end
  // When full, the write slot equals the head slot; a simultaneous pop frees it on the same edge.
  always_ff @(posedge clk_i) begin
    if (i_push) r_mem[r_wptr[AW-1:0]] <= i_data;
  end
  assign o_data  = r_mem[r_rptr[AW-1:0]];
  assign o_empty = r_wptr == r_rptr;
  assign o_full  = r_wptr == {~r_rptr[AW], r_rptr[AW-1:0]};
endmodule

// File: rtl/dcache_ecc_scrubber.sv
// dcache_ecc_scrubber: queues correctable ECC reports and rewrites each line with corrected data
// Ports: clk_i/rst_ni; err_* report in; req_o/addr_o/we_o/be_o/wdata_o to arbiter, gnt_i/rdata_i back;
// busy_o, uncorr_o/drop_o pulses, scrub_cnt_o. Define DCACHE_SCRUB_CNT_EN for a saturating scrub counter.
// Entry layout comes from std_cache_pkg, so DCACHE_SET_ASSOC/ADDR_WIDTH must match SCRUB_WAYS/SCRUB_AW.
module dcache_ecc_scrubber
  import std_cache_pkg::*;
#(
  parameter int DCACHE_SET_ASSOC = SCRUB_WAYS,
  parameter int ADDR_WIDTH       = SCRUB_AW,
  parameter int LINE_WIDTH       = 128,
  parameter int FIFO_DEPTH       = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        err_valid_i,
  input  logic                        err_uncorr_i,
  input  logic [DCACHE_SET_ASSOC-1:0] err_way_i,
  input  logic [ADDR_WIDTH-1:0]       err_addr_i,
  output logic [DCACHE_SET_ASSOC-1:0] req_o,
  input  logic                        gnt_i,
  output logic [ADDR_WIDTH-1:0]       addr_o,
  output logic                        we_o,
  output logic [LINE_WIDTH/8-1:0]     be_o,
  output logic [LINE_WIDTH-1:0]       wdata_o,
  input  logic [LINE_WIDTH-1:0]       rdata_i,
  output logic                        busy_o,
  output logic                        uncorr_o,
  output logic                        drop_o,
  output logic [15:0]                 scrub_cnt_o
);
  scrub_state_e          r_state, w_next;
  scrub_entry_t          w_in, w_head;
  logic                  w_full, w_empty, w_push, w_pop, w_corr;
  logic [LINE_WIDTH-1:0] r_line;
  logic                  r_uncorr, r_drop;
  assign w_in   = '{way: err_way_i, addr: err_addr_i};
  assign w_corr = err_valid_i & ~err_uncorr_i;
  assign w_pop  = (r_state == WR_REQ) & gnt_i;
  assign w_push = w_corr & (~w_full | w_pop);
  dcache_scrub_fifo #(.W($bits(scrub_entry_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_in),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_line   <= '0;
      r_uncorr <= 1'b0;
      r_drop   <= 1'b0;
    end else begin
      if (r_state == RD_WAIT) r_line <= rdata_i;
      r_uncorr <= err_valid_i & err_uncorr_i;
      r_drop   <= w_corr & w_full & ~w_pop;
    end
  end
  always_comb begin
    w_next  = r_state;
    req_o   = '0;
    addr_o  = '0;
    we_o    = 1'b0;
    be_o    = '0;
    wdata_o = '0;
    case (r_state)
      IDLE:    w_next = w_empty ? IDLE : RD_REQ;
      RD_REQ: begin
        req_o  = w_head.way;
        addr_o = w_head.addr;
        w_next = gnt_i ? RD_WAIT : RD_REQ;
      end
      RD_WAIT: w_next = WR_REQ;
      WR_REQ: begin
        req_o   = w_head.way;
        addr_o  = w_head.addr;
        we_o    = 1'b1;
        be_o    = '1;
        wdata_o = r_line;
        w_next  = gnt_i ? IDLE : WR_REQ;
      end
      default: w_next = IDLE;
    endcase
  end
  assign busy_o   = (r_state != IDLE) | ~w_empty;
  assign uncorr_o = r_uncorr;
  assign drop_o   = r_drop;
`ifdef DCACHE_SCRUB_CNT_EN
  logic [15:0] r_scrub_cnt;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_scrub_cnt <= '0;
    else if (w_pop && r_scrub_cnt != 16'hFFFF) r_scrub_cnt <= r_scrub_cnt + 16'd1;
  end
  assign scrub_cnt_o = r_scrub_cnt;
`else
  assign scrub_cnt_o = 16'h0;
`endif
endmodule

// File: doc/dcache_ecc_scrubber.md
DCACHE_ECC_SCRUBBER -- requirements
Module: dcache_ecc_scrubber

Interface
REQ-001 SHALL have parameter DCACHE_SET_ASSOC, default 8, number of ways.
REQ-002 SHALL have parameter ADDR_WIDTH, default 64, width of the set-index address presented to the cache arbiter.
REQ-003 SHALL have parameter LINE_WIDTH, default 128, data line width in bits; NBYTES = LINE_WIDTH/8.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, number of pending scrub entries (power of two, at least 2).
REQ-005 SHALL have port clk_i, input, 1, clock; one clock only.
REQ-006 SHALL have port rst_ni, input, 1, reset; asynchronous, active-low.
REQ-007 SHALL have port err_valid_i, input, 1, error report strobe from the tag-compare/ECC decode stage.
REQ-008 SHALL have port err_uncorr_i, input, 1, reported error is uncorrectable.
REQ-009 SHALL have port err_way_i, input, DCACHE_SET_ASSOC, one-hot way that reported the error.
REQ-010 SHALL have port err_addr_i, input, ADDR_WIDTH, address of the erroneous line.
REQ-011 SHALL have port req_o, input/output: output, DCACHE_SET_ASSOC, per-way request to the cache arbiter port.
REQ-012 SHALL have port gnt_i, input, 1, arbiter grant.
REQ-013 SHALL have port addr_o, output, ADDR_WIDTH, request address.
REQ-014 SHALL have port we_o, output, 1, write enable.
REQ-015 SHALL have port be_o, output, NBYTES, byte enables.
REQ-016 SHALL have port wdata_o, output, LINE_WIDTH, corrected write-back data.
REQ-017 SHALL have port rdata_i, input, LINE_WIDTH, decoded (corrected) read data of the requested way, valid one cycle after the read grant.
REQ-018 SHALL have port busy_o, output, 1, FSM not in IDLE or FIFO non-empty.
REQ-019 SHALL have port uncorr_o, output, 1, one-cycle pulse for an uncorrectable report.
REQ-020 SHALL have port drop_o, output, 1, one-cycle pulse when a correctable report is lost to overflow.
REQ-021 SHALL have port scrub_cnt_o, output, 16, count of completed scrubs.

Function
REQ-022 SHALL push {err_way_i, err_addr_i} into the FIFO when err_valid_i=1, err_uncorr_i=0, and the FIFO is not full or a pop occurs in the same cycle.
REQ-023 SHALL NOT queue an uncorrectable report, and SHALL assert uncorr_o in the cycle after it.
REQ-024 SHALL assert drop_o in the cycle after a correctable report arrives while the FIFO is full with no simultaneous pop; FIFO contents SHALL remain unchanged.
REQ-025 SHALL implement the FSM states IDLE, RD_REQ, RD_WAIT, WR_REQ.
REQ-026 SHALL transition IDLE to RD_REQ when the FIFO is non-empty.
REQ-027 In RD_REQ, SHALL drive req_o = head way, addr_o = head address, we_o = 0, be_o = 0, and transition to RD_WAIT on gnt_i.
REQ-028 In RD_WAIT, SHALL capture rdata_i into the line register and transition to WR_REQ.
REQ-029 In WR_REQ, SHALL drive req_o = head way, addr_o = head address, we_o = 1, be_o = all ones, wdata_o = line register; on gnt_i it SHALL pop the FIFO, increment the count, and return to IDLE.
REQ-030 SHALL hold outputs stable while gnt_i=0, with no timeout.
REQ-031 SHALL drive req_o, we_o, be_o, wdata_o and addr_o to 0 in IDLE and RD_WAIT.
REQ-032 SHALL take a minimum of 4 cycles per entry, from IDLE with the FIFO non-empty back to IDLE, with the grant in the same cycle as the request.

Reset
REQ-033 Reset SHALL take effect asynchronously: FSM to IDLE, FIFO empty, line register 0, scrub_cnt_o 0, and all outputs 0.
REQ-034 A reset mid-scrub SHALL abandon the in-flight entry with no write issued.

Configuration
REQ-035 With DCACHE_SCRUB_CNT_EN defined, scrub_cnt_o SHALL increment on each WR_REQ grant and saturate at 16'hFFFF.
REQ-036 Without DCACHE_SCRUB_CNT_EN, scrub_cnt_o SHALL be tied to 0 and no counter flops shall exist.

Structure
REQ-037 std_cache_pkg SHALL hold the typedef scrub_entry_t {way, addr} and the enum scrub_state_e.
REQ-038 The FIFO SHALL be one sub-module, dcache_scrub_fifo, with push/pop/full/empty flags and same-cycle push+pop when full.

Verification
REQ-039 Single correctable report (way 8'h04, addr 0x40), gnt_i tied 1 -> read request at cycle +2, write of captured rdata_i with be_o all ones at cycle +4, scrub_cnt_o = 1.
REQ-040 Uncorrectable report -> uncorr_o pulse at the next cycle, req_o stays 0, FIFO empty.
REQ-041 Five back-to-back reports with gnt_i=0 -> four queued, drop_o pulse for the fifth, then gnt_i=1 -> four scrubs in FIFO order.
REQ-042 Report while FIFO is full, coincident with a WR_REQ grant -> accepted, no drop_o.
REQ-043 rst_ni asserted during RD_WAIT -> no write issued, busy_o=0, scrub_cnt_o=0.
REQ-044 With DCACHE_SCRUB_CNT_EN, counter preloaded near 16'hFFFF plus two scrubs -> scrub_cnt_o holds 16'hFFFF.
